// File: rtl/spi_pkg.sv
// Shared definitions for the serial control bus: frame layout, controller
// states and the peripheral register map.
package spi_pkg;
   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT,
      ST_TRAIL,
      ST_GAP
   } ctrl_state_t;

   localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'd0;
   localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'd1;
   localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'd2;
   localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'd3;
   localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'd4;

   function automatic logic [FRAME_W-1:0] pack_frame(
      input logic              rw,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      return {rw, addr, data};
   endfunction
endpackage

// File: rtl/spi_controller_if.sv
// Command handshake between a requester and the SPI controller.
interface spi_controller_if;
   import spi_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              busy;
   logic              done;

   modport master (
      output req_valid, req_rw, req_addr, req_data,
      input  req_ready, busy, done
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_data,
      output req_ready, busy, done
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period timer: down-counter that pulses half_tick on terminal count
// once every CLK_DIV cycles while running.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic half_tick
);
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= RELOAD;
      end else if (clear) begin
         cnt <= RELOAD;
      end else if (run) begin
         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
      end
   end

   assign half_tick = run && !clear && (cnt == '0);
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {rw, addr, data} frame per
// accepted command on nCS/SCLK/COPI, MSB first, then holds an inter-frame gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nCS high, ready for a command
// ST_LEAD  | nCS low, SCLK low, first bit set up for one half-period
// ST_SHIFT | 16 bits, each one half-period high then (except last) low
// ST_TRAIL | SCLK low one half-period after the last bit, COPI holds bit 0
// ST_GAP   | nCS high for GAP_CYCLES before returning to idle
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spi_controller_if.slave        bus,
   output logic                   nCS,
   output logic                   SCLK,
   output logic                   COPI
);
   localparam int GAP_W = $clog2(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

   ctrl_state_t        state_q, state_d;
   logic               ncs_q, ncs_d;
   logic               sclk_q, sclk_d;
   logic               copi_q, copi_d;
   logic               done_q, done_d;
   logic [FRAME_W-1:0] shreg_q, shreg_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [FRAME_W-1:0] frame_in;
   logic               half_tick;
   logic               sclk_run;
   logic               sclk_clear;

   assign sclk_run   = (state_q == ST_LEAD) || (state_q == ST_SHIFT) || (state_q == ST_TRAIL);
   assign sclk_clear = (state_q == ST_IDLE) || (state_q == ST_GAP);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (sclk_run),
      .clear     (sclk_clear),
      .half_tick (half_tick)
   );

   assign frame_in = pack_frame(bus.req_rw, bus.req_addr, bus.req_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ncs_q     <= 1'b1;
         sclk_q    <= 1'b0;
         copi_q    <= 1'b0;
         done_q    <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ncs_q     <= ncs_d;
         sclk_q    <= sclk_d;
         copi_q    <= copi_d;
         done_q    <= done_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ncs_d     = ncs_q;
      sclk_d    = sclk_q;
      copi_d    = copi_q;
      done_d    = 1'b0;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               shreg_d   = frame_in;
               copi_d    = frame_in[FRAME_W-1];
               ncs_d     = 1'b0;
               sclk_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = ST_LEAD;
            end
         end
         ST_LEAD: begin
            if (half_tick) begin
               sclk_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (half_tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  // bit_cnt counts falling edges; the 16th high half ends the frame
                  if (bit_cnt_q == 4'd15) begin
                     state_d = ST_TRAIL;
                  end else begin
                     shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                     copi_d    = shreg_q[FRAME_W-2];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end else begin
                  sclk_d = 1'b1;
               end
            end
         end
         ST_TRAIL: begin
            if (half_tick) begin
               ncs_d     = 1'b1;
               copi_d    = 1'b0;
               done_d    = 1'b1;
               gap_cnt_d = GAP_RELOAD;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign nCS           = ncs_q;
   assign SCLK          = sclk_q;
   assign COPI          = copi_q;
   assign bus.done      = done_q;
   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: drives random and directed commands and decodes
// the serial bus into a register-file model of the peripheral.
module tb_spi_controller;
   import spi_pkg::*;

   localparam int unsigned CLK_DIV    = 4;
   localparam int unsigned GAP_CYCLES = 8;

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ncs, sclk, copi;

   spi_controller_if bus ();

   spi_controller #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .nCS   (ncs),
      .SCLK  (sclk),
      .COPI  (copi)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_t              exp_q[$];
   logic [DATA_W-1:0] model_regs [128];
   logic [DATA_W-1:0] obs_regs   [128];

   // Bus monitor / behavioural receiver
   int           acc_cyc = 0, end_cyc = 0, last_chg = 0, gap_seen = 0;
   int           nrise = 0, rise_err = 0, frames = 0;
   bit           end_valid = 0;
   logic [15:0]  got = '0;
   logic         p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_ready = 1'b1;
   cmd_t         cm;

   always @(negedge clk) begin
      if (!rst_n) begin
         end_valid = 0;
         nrise     = 0;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            acc_cyc  = cyc;
            nrise    = 0;
            rise_err = 0;
            got      = '0;
            last_chg = cyc + 1;
         end
         if (copi !== p_copi) begin
            check_val("copi_change_while_sclk_high", sclk, 0);
            last_chg = cyc;
         end
         if (p_ncs && !ncs) begin
            check_val("ncs_fall_delay", cyc - acc_cyc, 1);
            if (end_valid) gap_seen = cyc - end_cyc;
         end
         if (!p_sclk && sclk) begin
            if (cyc != acc_cyc + 1 + CLK_DIV + 2 * nrise * CLK_DIV) rise_err++;
            if (cyc - last_chg < CLK_DIV) rise_err++;
            got   = {got[14:0], copi};
            nrise = nrise + 1;
         end
         if (!p_ncs && ncs) begin
            check_val("ncs_rise_delay", cyc - acc_cyc, 1 + 33 * CLK_DIV);
            check_val("done_at_frame_end", bus.done, 1);
            check_val("rise_count", nrise, 16);
            check_val("rise_timing_errors", rise_err, 0);
            if (exp_q.size() == 0) begin
               check_val("unexpected_frame", 1, 0);
            end else begin
               cm = exp_q.pop_front();
               check_val("frame_bits", got,
                         int'(cm.rw) * 32768 + int'(cm.addr) * 256 + int'(cm.data));
               if (cm.rw == RW_WRITE) model_regs[cm.addr] = cm.data;
            end
            if (got[15] == RW_WRITE) obs_regs[got[14:8]] = got[7:0];
            end_cyc   = cyc;
            end_valid = 1;
            frames++;
         end else if (bus.done) begin
            check_val("done_spurious", bus.done, 0);
         end
         if (!p_ready && bus.req_ready && end_valid)
            check_val("ready_after_gap", cyc - end_cyc, GAP_CYCLES);
      end
      p_ncs   = ncs;
      p_sclk  = sclk;
      p_copi  = copi;
      p_ready = bus.req_ready;
   end

   // Call at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic rw, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input bit hold);
      cmd_t c;
      bit   ok = 0;
      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_data  = data;
      bus.req_valid = 1'b1;
      for (int n = 0; n < 2000 && !ok; n++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1;
      end
      if (!ok) begin
         check_val("accept_timeout", 0, 1);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      c.rw = rw; c.addr = addr; c.data = data;
      exp_q.push_back(c);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      for (int n = 0; n < 5000 && frames < target; n++) @(posedge clk);
      if (frames < target) check_val("frame_timeout", frames, target);
      for (int n = 0; n < 100 && !bus.req_ready; n++) @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   int n_sent = 0;
   int mism   = 0;
   logic r_rw;
   bit   r_hold;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < 128; i++) begin
         model_regs[i] = '0;
         obs_regs[i]   = '0;
      end

      // reset values, during and after reset
      #12;
      check_val("rst_ncs", ncs, 1);
      check_val("rst_sclk", sclk, 0);
      check_val("rst_copi", copi, 0);
      check_val("rst_ready", bus.req_ready, 1);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("post_rst_ncs", ncs, 1);
      check_val("post_rst_sclk", sclk, 0);
      check_val("post_rst_copi", copi, 0);
      check_val("post_rst_ready", bus.req_ready, 1);
      check_val("post_rst_busy", bus.busy, 0);
      check_val("post_rst_done", bus.done, 0);

      // single write with exact timing
      send(RW_WRITE, PWM_DUTY, 8'hA5, 0); n_sent++;
      check_val("busy_after_accept", bus.busy, 1);
      wait_frames(n_sent);
      check_val("single_write_reg", obs_regs[PWM_DUTY], 8'hA5);

      // back-to-back with valid held
      send(RW_WRITE, EN_OUT_7_0, 8'hFF, 1); n_sent++;
      send(RW_WRITE, PWM_DUTY, 8'h80, 0); n_sent++;
      wait_frames(n_sent);
      check_val("b2b_gap", gap_seen, GAP_CYCLES + 1);
      check_val("b2b_en_out_7_0", obs_regs[EN_OUT_7_0], 8'hFF);
      check_val("b2b_pwm_duty", obs_regs[PWM_DUTY], 8'h80);

      // read frame leaves the register untouched
      send(RW_WRITE, EN_PWM_7_0, 8'h5C, 0); n_sent++;
      send(1'b0, EN_PWM_7_0, 8'h3C, 0); n_sent++;
      wait_frames(n_sent);
      check_val("read_no_write", obs_regs[EN_PWM_7_0], 8'h5C);

      // reset after the 7th rising edge
      send(RW_WRITE, EN_PWM_15_8, 8'hC3, 0);
      for (int n = 0; n < 1000 && nrise < 7; n++) @(posedge clk);
      check_val("rise7_reached", nrise, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midrst_ncs", ncs, 1);
      check_val("midrst_sclk", sclk, 0);
      check_val("midrst_done", bus.done, 0);
      check_val("midrst_busy", bus.busy, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(RW_WRITE, EN_OUT_15_8, 8'h5A, 0); n_sent++;
      wait_frames(n_sent);
      check_val("after_rst_write", obs_regs[EN_OUT_15_8], 8'h5A);
      check_val("aborted_not_written", obs_regs[EN_PWM_15_8], 8'h00);

      // inputs changed while busy do not affect the frame
      send(RW_WRITE, EN_PWM_15_8, 8'h96, 0); n_sent++;
      repeat (20) @(posedge clk);
      #1;
      bus.req_data = 8'h11;
      wait_frames(n_sent);
      check_val("busy_change_ignored", obs_regs[EN_PWM_15_8], 8'h96);

      // random commands, some back-to-back
      for (int i = 0; i < 10; i++) begin
         r_rw   = 1'($urandom_range(0, 3) != 0);
         r_hold = bit'($urandom_range(0, 1));
         if (i == 9) r_hold = 0;
         send(r_rw, 7'($urandom_range(0, 7)), 8'($urandom), r_hold); n_sent++;
         if (!r_hold) repeat ($urandom_range(0, 5)) @(posedge clk);
      end
      bus.req_valid = 1'b0;
      wait_frames(n_sent);

      check_val("frames_total", frames, n_sent);
      check_val("queue_empty", exp_q.size(), 0);
      check_val("reg_en_out_7_0", obs_regs[EN_OUT_7_0], model_regs[EN_OUT_7_0]);
      check_val("reg_en_out_15_8", obs_regs[EN_OUT_15_8], model_regs[EN_OUT_15_8]);
      check_val("reg_en_pwm_7_0", obs_regs[EN_PWM_7_0], model_regs[EN_PWM_7_0]);
      check_val("reg_en_pwm_15_8", obs_regs[EN_PWM_15_8], model_regs[EN_PWM_15_8]);
      check_val("reg_pwm_duty", obs_regs[PWM_DUTY], model_regs[PWM_DUTY]);
      for (int i = 0; i < 128; i++) if (obs_regs[i] !== model_regs[i]) mism++;
      check_val("regfile_all", mism, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end
endmodule
